aes128_iter_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_mixcolumns.sv | 30 +++
 rtl/subbytes.sv | 33 +++
 rtl/aes128_iter_ctrl.sv | 109 ++++++++++
 tb/tb_aes128_iter_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        KEYSUB,
        STATESUB,
        DONE
    } state_t;

    localparam int unsigned NR = 10;

    // Indexed directly by the 4-bit round counter; entry 0 and 11..15 are never used.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// AES MixColumns over four column-major 32-bit columns, purely combinational.
module aes_mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        dout = '0;
        a0   = '0;
        a1   = '0;
        a2   = '0;
        a3   = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = din[127-32*c -: 8];
            a1 = din[119-32*c -: 8];
            a2 = din[111-32*c -: 8];
            a3 = din[103-32*c -: 8];
            // 3*x is xtime(x) ^ x
            dout[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            dout[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            dout[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            dout[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

endmodule

// File: rtl/subbytes.sv
// AES forward S-box applied to all 16 bytes of a 128-bit word, purely combinational.
module subbytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            dout[127-8*i -: 8] = SBOX[din[127-8*i -: 8]];
        end
    end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: ten two-cycle rounds sharing one subbytes instance
// between on-the-fly key expansion (KEYSUB) and the state datapath (STATESUB).
module aes128_iter_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round
);

    state_t       state, state_next;
    logic [127:0] st, rk, rk_next;
    logic [3:0]   rnd;
    logic [127:0] sb_in, sb_out, sr, mc;
    logic [31:0]  t, w0n, w1n, w2n, w3n;
    logic         last_rnd;

    assign last_rnd = (rnd == 4'(NR));
    assign sb_in    = (state == KEYSUB) ? {rot_word(rk[31:0]), 96'h0} : st;

    subbytes u_subbytes (
        .din  (sb_in),
        .dout (sb_out)
    );

    always_comb begin
        sr = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb_out[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    aes_mixcolumns u_mixcolumns (
        .din  (sr),
        .dout (mc)
    );

    always_comb begin
        t       = sb_out[127:96] ^ {RCON[rnd], 24'h0};
        w0n     = rk[127:96] ^ t;
        w1n     = rk[95:64]  ^ w0n;
        w2n     = rk[63:32]  ^ w1n;
        w3n     = rk[31:0]   ^ w2n;
        rk_next = {w0n, w1n, w2n, w3n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (in_valid) state_next = KEYSUB;
            KEYSUB:   state_next = STATESUB;
            STATESUB: state_next = last_rnd ? DONE : KEYSUB;
            DONE:     if (out_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == KEYSUB) || (state == STATESUB);
    end

    assign round      = rnd;
    assign ciphertext = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= '0;
            rk  <= '0;
            rnd <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    st  <= plaintext ^ key;
                    rk  <= key;
                    rnd <= 4'd1;
                end
                KEYSUB: rk <= rk_next;
                STATESUB: begin
                    if (last_rnd) begin
                        st <= sr ^ rk;
                    end else begin
                        st  <= mc ^ rk;
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: if (out_ready) rnd <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Scoreboard bench for aes128_iter_ctrl using the FIPS-197 reference vectors.
module tb_aes128_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;

    int unsigned  n_chk = 0;
    int unsigned  n_pass = 0;
    int unsigned  cyc = 0;
    logic [127:0] exp_q [$];

    aes128_iter_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round      (round)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_has_entry", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) check("ciphertext", ciphertext, exp_q.pop_front());
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_round"}, 128'(round), 128'd0);
        check({tag, "_ct"}, ciphertext, 128'd0);
    endtask

    task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp,
                        input bit keep, output int unsigned at);
        bit got = 1'b0;
        int unsigned n = 0;
        plaintext = p;
        key       = k;
        in_valid  = 1'b1;
        while (!got && n < 100) begin
            @(negedge clk);
            got = in_ready;
            tick();
            n++;
        end
        check("accept", 128'(got), 128'd1);
        if (got) exp_q.push_back(exp);
        at = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int unsigned n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        int unsigned n = 0;
        while (round != r && n < 100) begin
            tick();
            n++;
        end
        check("round_reached", 128'(round), 128'(r));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int unsigned at0, at1, lat;
        logic [127:0] held;

        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Vector 1: latency, then backpressure in DONE
        send(P1, K1, C1, 1'b0, at0);
        check("v1_round1", 128'(round), 128'd1);
        check("v1_busy", 128'(busy), 128'd1);
        wait_out(lat);
        check("v1_latency", 128'(lat), 128'd20);
        check("done_round", 128'(round), 128'd10);
        held = ciphertext;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_ct_stable", ciphertext, held);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
        end
        drain();
        check("post_hs_in_ready", 128'(in_ready), 128'd1);
        check("post_hs_round", 128'(round), 128'd0);

        // Vector 2: first round key
        send(P2, K2, C2, 1'b0, at0);
        tick();
        check("v2_rk1", dut.rk, RK1);
        wait_out(lat);
        drain();

        // Busy rejection during round 4
        send(P1, K1, C1, 1'b0, at0);
        wait_round(4'd4);
        plaintext = P2;
        key       = K2;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("busy_in_ready", 128'(in_ready), 128'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("early_out_ready_busy", 128'(busy), 128'd1);
        out_ready = 1'b0;
        wait_out(lat);
        drain();

        // Asynchronous reset mid-block
        send(P1, K1, C1, 1'b0, at0);
        wait_round(4'd5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        tick();
        rst = 1'b0;
        send(P2, K2, C2, 1'b0, at0);
        wait_out(lat);
        check("post_rst_latency", 128'(lat), 128'd20);
        drain();

        // Back-to-back with both handshakes held high
        out_ready = 1'b1;
        send(P1, K1, C1, 1'b1, at0);
        send(P2, K2, C2, 1'b0, at1);
        check("b2b_period", 128'(at1 - at0), 128'd22);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        out_ready = 1'b0;
        tick();
        check("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
